// File: rtl/pipelined_addsub_pkg.sv
// Shared defaults and elaboration-time helpers for the pipelined adder/subtractor.
// The WIDTH/STAGES geometry rule is kept here so every user of the block applies it the same way.
package pipelined_addsub_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // A legal geometry gives every stage the same whole number of bits.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder segment.
// It also reports the carry into its top bit, which the pipeline uses to derive signed overflow.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // NOTE: every variable written here gets a default first, so no path can leave a value held (no latch).
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit adder/subtractor split into STAGES registered carry-chain segments with
// valid/ready handshakes on both sides; fixed latency of STAGES cycles, one op per clock.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!geometry_ok(WIDTH, STAGES)) begin : g_geometry_check
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Per-stage registers: valid, operands still to be added, finished low bits, running carry,
  // and the carry into the current chunk's top bit (meaningful as overflow input at the last stage).
  logic             v_q  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic             c_q  [STAGES];
  logic             cm_q [STAGES];

  logic stall;

  assign out_valid = v_q[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  assign Sum  = s_q[STAGES-1];
  assign Cout = c_q[STAGES-1];
  assign Ovf  = c_q[STAGES-1] ^ cm_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_i;
    logic             c_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic [WIDTH-1:0] s_n;
    logic [CHUNK-1:0] s_chunk;
    logic             co;
    logic             cm;

    if (k == 0) begin : g_entry
      // Subtraction becomes A + ~B + Cin here; the Sub bit goes no further.
      assign v_i = in_valid & in_ready;
      assign a_i = A;
      assign b_i = B ^ {WIDTH{Sub}};
      assign c_i = Cin;
      assign s_i = '0;
    end else begin : g_link
      assign v_i = v_q[k-1];
      assign a_i = a_q[k-1];
      assign b_i = b_q[k-1];
      assign c_i = c_q[k-1];
      assign s_i = s_q[k-1];
    end

    addsub_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a    (a_i[k*CHUNK +: CHUNK]),
      .b    (b_i[k*CHUNK +: CHUNK]),
      .ci   (c_i),
      .s    (s_chunk),
      .co   (co),
      .c_msb(cm)
    );

    always_comb begin
      s_n                    = s_i;
      s_n[k*CHUNK +: CHUNK]  = s_chunk;
    end

    // NOTE: state is written with non-blocking assignments so every stage samples its
    // predecessor's pre-edge value, regardless of the order the simulator runs these blocks.
    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: the datapath registers are reset as well as the valid bits, because the
        // result outputs must read zero after reset.
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        cm_q[k] <= 1'b0;
      end else if (!stall) begin
        v_q[k] <= v_i;
        // Bubbles do not overwrite data, so the outputs only change when a real result lands.
        if (v_i) begin
          a_q[k]  <= a_i;
          b_q[k]  <= b_i;
          s_q[k]  <= s_n;
          c_q[k]  <= co;
          cm_q[k] <= cm;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub at (16,4), (4,1) and (4,4): drivers push hand-computed
// results into per-instance queues, and negedge monitors pop and compare on every output transfer.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    int          acc;
    bit          lat;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        out_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Sub;

  logic        iv16, ir16, ov16, co16, of16;
  logic [15:0] sum16;
  logic        iv41, ir41, ov41, co41, of41;
  logic [3:0]  sum41;
  logic        iv44, ir44, ov44, co44, of44;
  logic [3:0]  sum44;

  exp_t q16[$];
  exp_t q41[$];
  exp_t q44[$];

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(ov16), .out_ready(out_ready), .Sum(sum16), .Cout(co16), .Ovf(of16)
  );

  pipelined_addsub #(.WIDTH(4), .STAGES(1)) u_d41 (
    .clk(clk), .rst(rst), .in_valid(iv41), .in_ready(ir41), .A(A[3:0]), .B(B[3:0]), .Cin(Cin),
    .Sub(Sub), .out_valid(ov41), .out_ready(out_ready), .Sum(sum41), .Cout(co41), .Ovf(of41)
  );

  pipelined_addsub #(.WIDTH(4), .STAGES(4)) u_d44 (
    .clk(clk), .rst(rst), .in_valid(iv44), .in_ready(ir44), .A(A[3:0]), .B(B[3:0]), .Cin(Cin),
    .Sub(Sub), .out_valid(ov44), .out_ready(out_ready), .Sum(sum44), .Cout(co44), .Ovf(of44)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed vectors: a, b, cin, sub, sum, cout, ovf.
  vec_t dir16 [5] = '{
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1}
  };

  vec_t dir4 [6] = '{
    '{16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0},
    '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000E, 1'b0, 1'b0},
    '{16'h0008, 16'h0001, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b1},
    '{16'h0002, 16'h000F, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0}
  };

  vec_t stream [8] = '{
    '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0},
    '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0},
    '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0},
    '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0},
    '{16'h7FFE, 16'h0000, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0}
  };

  vec_t discard [4] = '{
    '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0},
    '{16'h4444, 16'h1111, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
    '{16'h0F0F, 16'h00F0, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0}
  };

  vec_t one_plus_one = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic flag(input string nm, input string what);
    n_check++;
    n_fail++;
    $display("FAIL %s: %s", nm, what);
  endtask

  task automatic compare(input exp_t e, input logic [15:0] s, input logic co, input logic ov,
                         input int stages);
    check({e.nm, ".sum"}, 32'(s), 32'(e.sum));
    check({e.nm, ".cout"}, 32'(co), 32'(e.co));
    check({e.nm, ".ovf"}, 32'(ov), 32'(e.ov));
    if (e.lat) check({e.nm, ".latency"}, cyc - e.acc, stages - 1);
  endtask

  always @(negedge clk) begin
    if (ov16 === 1'b1 && out_ready === 1'b1) begin
      if (q16.size() == 0) flag("d16.output", "valid result with nothing expected");
      else compare(q16.pop_front(), sum16, co16, of16, 4);
    end
  end

  always @(negedge clk) begin
    if (ov41 === 1'b1 && out_ready === 1'b1) begin
      if (q41.size() == 0) flag("d41.output", "valid result with nothing expected");
      else compare(q41.pop_front(), {12'h000, sum41}, co41, of41, 1);
    end
  end

  always @(negedge clk) begin
    if (ov44 === 1'b1 && out_ready === 1'b1) begin
      if (q44.size() == 0) flag("d44.output", "valid result with nothing expected");
      else compare(q44.pop_front(), {12'h000, sum44}, co44, of44, 4);
    end
  end

  function automatic logic ready_of(input int d);
    case (d)
      0:       return ir16;
      1:       return ir41;
      default: return ir44;
    endcase
  endfunction

  task automatic set_valid(input int d, input logic v);
    case (d)
      0:       iv16 = v;
      1:       iv41 = v;
      default: iv44 = v;
    endcase
  endtask

  // Presents one op from a negedge until accepted; pushes its expected result when asked.
  task automatic issue(input int d, input vec_t v, input string nm, input bit push, input bit lat);
    bit   acc;
    int   guard;
    exp_t e;
    acc   = 1'b0;
    guard = 0;
    @(negedge clk);
    A   = v.a;
    B   = v.b;
    Cin = v.ci;
    Sub = v.sb;
    set_valid(d, 1'b1);
    while (!acc && guard < 100) begin
      #1 acc = (ready_of(d) === 1'b1);
      @(posedge clk);
      #1;
      guard++;
    end
    set_valid(d, 1'b0);
    if (!acc) begin
      flag({nm, ".accept"}, "input never accepted within 100 cycles");
    end else if (push) begin
      e.sum = v.sum;
      e.co  = v.co;
      e.ov  = v.ov;
      e.acc = cyc;
      e.lat = lat;
      e.nm  = nm;
      case (d)
        0:       q16.push_back(e);
        1:       q41.push_back(e);
        default: q44.push_back(e);
      endcase
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q16.size() + q41.size() + q44.size()) != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check({nm, ".pending_results"}, q16.size() + q41.size() + q44.size(), 0);
    q16.delete();
    q41.delete();
    q44.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem;
    rst       = 1'b1;
    out_ready = 1'b1;
    iv16      = 1'b0;
    iv41      = 1'b0;
    iv44      = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    Sub       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of every instance.
    @(negedge clk);
    check("d16.reset.out_valid", ov16, 0);
    check("d16.reset.sum", sum16, 0);
    check("d16.reset.cout", co16, 0);
    check("d16.reset.ovf", of16, 0);
    check("d16.reset.in_ready", ir16, 1);
    check("d41.reset.out_valid", ov41, 0);
    check("d41.reset.sum", sum41, 0);
    check("d41.reset.in_ready", ir41, 1);
    check("d44.reset.out_valid", ov44, 0);
    check("d44.reset.sum", sum44, 0);
    check("d44.reset.in_ready", ir44, 1);

    // Carry, signed overflow and subtract/borrow cases at each geometry.
    for (int i = 0; i < 5; i++) issue(0, dir16[i], $sformatf("d16.dir%0d", i), 1'b1, 1'b1);
    drain("d16.dir");
    for (int i = 0; i < 6; i++) issue(1, dir4[i], $sformatf("d41.dir%0d", i), 1'b1, 1'b1);
    drain("d41.dir");
    for (int i = 0; i < 6; i++) issue(2, dir4[i], $sformatf("d44.dir%0d", i), 1'b1, 1'b1);
    drain("d44.dir");

    // Back-to-back stream with a three-cycle downstream stall.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(0, stream[i], $sformatf("d16.stream%0d", i), 1'b1, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #2;
          check("stall.in_ready", ir16, 0);
          check("stall.out_valid", ov16, 1);
          if (q16.size() == 0) begin
            flag("stall.head", "no result outstanding during stall");
          end else begin
            check("stall.sum_hold", sum16, q16[0].sum);
            check("stall.cout_hold", co16, q16[0].co);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        rem = q16.size();
        for (int i = 0; i < rem; i++) begin
          @(negedge clk);
          #2;
          check("stream.no_gap", ov16, 1);
        end
      end
    join
    drain("d16.stream");

    // Three ops in flight, then reset together with a fourth offer: none may emerge.
    for (int i = 0; i < 3; i++) issue(0, discard[i], "d16.discard", 1'b0, 1'b0);
    @(negedge clk);
    A    = discard[3].a;
    B    = discard[3].b;
    Cin  = discard[3].ci;
    Sub  = discard[3].sb;
    iv16 = 1'b1;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    iv16 = 1'b0;
    @(negedge clk);
    check("rst.sum", sum16, 0);
    check("rst.in_ready", ir16, 1);
    for (int i = 0; i < 8; i++) begin
      check("rst.out_valid", ov16, 0);
      @(negedge clk);
    end
    issue(0, one_plus_one, "d16.after_rst", 1'b1, 1'b1);
    drain("d16.after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised successor to the 4-bit full adder: a WIDTH-bit adder/subtractor split into STAGES registered carry-chain segments. Uses a valid/ready handshake on input and output, so it can sit between streaming datapath blocks (pixel/feature accumulation ahead of the NN layers). Throughput is one operation per clock when not stalled. Latency is fixed at STAGES cycles.

Parameters:
WIDTH, 16, operand and result width in bits; must be divisible by STAGES.
STAGES, 4, number of pipeline segments; 1..WIDTH. CHUNK = WIDTH/STAGES bits are resolved per stage.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  A/B/Cin/Sub are valid this cycle.
in_ready  out  1  block accepts input this cycle.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B.
Cin  in  1  carry-in (borrow-not for subtract).
Sub  in  1  0 = add, 1 = subtract.
out_valid  out  1  result fields valid.
out_ready  in  1  downstream accepts result.
Sum  out  WIDTH  result.
Cout  out  1  carry out of MSB.
Ovf  out  1  two's-complement signed overflow.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Arithmetic:
  - Sub=0: {Cout,Sum} = A + B + Cin.
  - Sub=1: {Cout,Sum} = A + ~B + Cin. With Cin=1 this gives A−B; Cout=0 means borrow.
  - Ovf = carry into bit WIDTH−1 XOR Cout.
  - All widths are exact; no truncation other than the defined WIDTH-bit Sum.
- Pipeline structure:
  - Stage k (0..STAGES−1) adds bits [k*CHUNK +: CHUNK] using the carry registered by stage k−1. Stage 0 uses Cin.
  - Each stage register holds: a valid bit, the completed lower result bits, the unprocessed upper A and ~B-adjusted B bits, the running carry, and the carry-into-MSB when it is produced.
  - Operands are inverted for Sub at stage-0 entry. No Sub bit travels further.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is transferred when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - On stall, all stage registers hold. Otherwise every stage advances, and bubbles advance as invalid entries.
  - Sum/Cout/Ovf are held stable while out_valid && !out_ready.
- Latency: an input accepted at edge t with no stall gives out_valid=1 after edge t+STAGES−1. Results appear STAGES cycles after acceptance. Order is strictly preserved; there is no loss or duplication.
- Reset:
  - All valid bits clear; out_valid=0, Sum=0, Cout=0, Ovf=0. in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight entries; none reappear.
  - rst has priority over any simultaneous handshake.
- Boundaries:
  - Simultaneous output transfer and input accept in the same cycle is legal; full throughput is maintained.
  - STAGES=1 degenerates to a single registered adder with latency 1.
  - STAGES=WIDTH gives 1-bit chunks.
  - Data inputs are don't-care when in_valid=0; no X propagates into valid bits.
- Expected size: roughly 150–250 lines of RTL (generate loop over stages).

Decomposition:
- No shared package types needed. CHUNK is a localparam. Derive the WIDTH%STAGES check via a generate-time error.
- One sub-module: addsub_chunk.
  - Combinational CHUNK-bit ripple adder.
  - Inputs: a, b, ci. Outputs: s, co, c_msb (carry into top bit).
  - Instantiated once per stage.

Test Plan:
1. Default params; A=0x00FF, B=0x0001, Cin=0, Sub=0 → Sum=0x0100, Cout=0, Ovf=0; out_valid exactly 4 cycles after acceptance.
2. A=0xFFFF, B=0x0001, Cin=0, Sub=0 → Sum=0x0000, Cout=1, Ovf=0. Then A=0x7FFF, B=0x0001 → Sum=0x8000, Cout=0, Ovf=1.
3. Sub=1, Cin=1: A=0x0005, B=0x0007 → Sum=0xFFFE, Cout=0, Ovf=0. Then A=0x8000, B=0x0001 → Sum=0x7FFF, Cout=1, Ovf=1.
4. Stream 8 back-to-back random ops with out_ready held low for 3 cycles mid-stream → in_ready=0 during the stall, outputs stable while stalled, all 8 results in order matching the reference model, with no gaps once out_ready returns high.
5. Accept 3 ops, assert rst for 1 cycle with in_valid=1 → out_valid=0 from the next cycle, none of the 3 (or the concurrent op) ever emitted. Then a new op A=0x0001, B=0x0001 → Sum=0x0002 after 4 cycles.
6. Re-run scenarios 1–3 at (WIDTH=4, STAGES=1) and (WIDTH=4, STAGES=4) → identical arithmetic results with latency 1 and 4 respectively. Include 4'b0010+4'b1111 → Sum=4'b0001, Cout=1.
